// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter between
// NUM_REQ valid/ready requesters, with burst locking and a write-to-busy watchdog.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WDOG    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_wr_en,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        locked,
    output logic                        err
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(WDOG + 1);

    typedef enum logic [1:0] {ARB, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt, grant_nxt, pick;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]  data_nxt, pick_data;
    logic [NUM_REQ-1:0] elig;
    logic               found, pick_last, wr_nxt, lock_nxt, err_nxt;

    // Eligible set and wrapped first-from-ptr selection
    always_comb begin
        elig      = '0;
        found     = 1'b0;
        pick      = '0;
        pick_data = '0;
        pick_last = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            elig[j] = req_valid[j] && (!locked || grant_id == IDX_W'(j));
        end
        // Lowest eligible index overall, then overridden by the lowest at or above ptr
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (elig[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (elig[j] && IDX_W'(j) >= ptr) begin
                pick = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == IDX_W'(j)) begin
                pick_data = req_data[j*DATA_W +: DATA_W];
                pick_last = req_last[j];
            end
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant_id;
        data_nxt  = tx_data;
        lock_nxt  = locked;
        cnt_nxt   = cnt;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
        req_ready = '0;
        case (state)
            ARB: begin
                if (!tx_busy && found) begin
                    for (int j = 0; j < NUM_REQ; j++) begin
                        req_ready[j] = (pick == IDX_W'(j));
                    end
                    data_nxt  = pick_data;
                    grant_nxt = pick;
                    ptr_nxt   = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
                    lock_nxt  = !pick_last;
                    wr_nxt    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_W'(WDOG - 1)) begin
                    err_nxt   = 1'b1;
                    lock_nxt  = 1'b0;
                    state_nxt = ARB;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB;
            ptr      <= '0;
            cnt      <= '0;
            grant_id <= '0;
            tx_data  <= '0;
            locked   <= 1'b0;
            tx_wr_en <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            grant_id <= grant_nxt;
            tx_data  <= data_nxt;
            locked   <= lock_nxt;
            tx_wr_en <= wr_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios plus randomized traffic, checked every
// cycle against a timestamp-based behavioural model of the scheduler.
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int WD = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_wr_en;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           locked;
    logic           err;

    uart_tx_sched #(.NUM_REQ(N), .DATA_W(W), .WDOG(WD)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_wr_en(tx_wr_en), .tx_busy(tx_busy), .grant_id(grant_id),
        .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int glog[$];
    bit mon = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter stand-in: busy rises 2 cycles after the write pulse
    int rise_t = -1, fall_t = -1, fixed_len = 0;
    bit tx_alive = 1'b1, busy_force = 1'b0, busy_forced = 1'b0;

    always @(posedge clk) begin
        #2;
        busy_forced = busy_force;
        tx_busy = busy_force || (cyc >= rise_t && cyc < fall_t);
    end

    // Behavioural model: timestamps of the write pulse and of the expected error
    bit           m_idle = 1'b1, m_seen = 1'b0, m_lock = 1'b0;
    int           m_ptr = 0, m_gid = 0, m_wr_t = -1, m_err_t = -1;
    logic [W-1:0] m_data = '0;
    int           mp;
    logic [N-1:0] mrdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            rise_t = -1;
            fall_t = -1;
        end else if (tx_wr_en === 1'b1 && tx_alive) begin
            rise_t = cyc + 2;
            fall_t = rise_t + ((fixed_len > 0) ? fixed_len : int'($urandom_range(8, 1)));
        end

        mp   = -1;
        mrdy = '0;
        if (m_idle && !tx_busy) begin
            for (int k = 0; k < N; k++) begin
                if (mp < 0 && req_valid[(m_ptr + k) % N] && (!m_lock || (m_ptr + k) % N == m_gid))
                    mp = (m_ptr + k) % N;
            end
        end
        if (mp >= 0) mrdy[mp] = 1'b1;

        if (mon) begin
            chk("req_ready", req_ready, mrdy);
            chk("tx_wr_en", tx_wr_en, cyc == m_wr_t);
            chk("err", err, cyc == m_err_t);
            chk("tx_data", tx_data, m_data);
            chk("grant_id", grant_id, m_gid);
            chk("locked", locked, m_lock);
            if (!busy_forced) chk("wr_busy_overlap", tx_wr_en & tx_busy, 0);
        end
        if (rst_n) begin
            for (int k = 0; k < N; k++)
                if (req_valid[k] && req_ready[k]) glog.push_back(k);
        end

        if (!rst_n) begin
            m_idle = 1'b1; m_seen = 1'b0; m_lock = 1'b0; m_ptr = 0; m_gid = 0;
            m_data = '0; m_wr_t = -1; m_err_t = -1;
        end else if (mp >= 0) begin
            m_data = req_data[mp*W +: W];
            m_gid  = mp;
            m_ptr  = (mp + 1) % N;
            m_lock = !req_last[mp];
            m_wr_t = cyc + 1;
            m_idle = 1'b0;
            m_seen = 1'b0;
        end else if (!m_idle && cyc > m_wr_t) begin
            if (m_seen) begin
                if (!tx_busy) m_idle = 1'b1;
            end else if (tx_busy) begin
                m_seen = 1'b1;
            end else if (cyc - m_wr_t == WD) begin
                m_err_t = cyc + 1;
                m_idle  = 1'b1;
                m_lock  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic l);
        req_valid[i]     = v;
        req_data[i*W +: W] = d;
        req_last[i]      = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        glog.delete();
    endtask

    task automatic wait_grants(input int n, input string name);
        int k;
        k = 0;
        tick();
        while (glog.size() < n && k < 500) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 500) begin
            errors++;
            $display("FAIL %s: grants seen %0d, expected %0d before timeout", name, glog.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        tick();
        while (!(m_idle && !tx_busy) && k < 500) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 500) begin
            errors++;
            $display("FAIL %s: idle not reached, got busy=%0b expected 0", name, tx_busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int exp_rr[5];
        int exp_bl[5];
        int lt, ecyc, n;
        exp_rr = '{0, 1, 2, 3, 0};
        exp_bl = '{1, 1, 1, 3, 0};

        tick();
        rst_n = 1'b1;
        mon = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr", tx_wr_en, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_lock", locked, 0);
        chk("rst_err", err, 0);

        // Single word from requester 2
        do_reset();
        fixed_len = 20;
        set_req(2, 1'b1, 16'h00A5, 1'b1);
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_wr", tx_wr_en, 1);
        chk("t1_data", tx_data, 16'h00A5);
        chk("t1_gid", grant_id, 2);
        chk("t1_lock", locked, 0);
        tick();
        @(negedge clk);
        chk("t1_wr_off", tx_wr_en, 0);
        for (int i = 0; i < 25; i++) begin
            tick();
            @(negedge clk);
            if (tx_busy) chk("t1_hold", tx_data, 16'h00A5);
        end
        wait_idle("t1_idle");

        // Round-robin with all requesters continuously valid
        do_reset();
        fixed_len = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, W'($urandom), 1'b1);
        wait_grants(5, "t2_grants");
        req_valid = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), glog[i], exp_rr[i]);
        wait_idle("t2_idle");

        // Burst lock held by requester 1
        do_reset();
        set_req(1, 1'b1, 16'h1111, 1'b0);
        wait_grants(1, "t3_g1");
        chk("t3_lock1", locked, 1);
        set_req(0, 1'b1, 16'h0A0A, 1'b1);
        set_req(3, 1'b1, 16'h3333, 1'b1);
        set_req(1, 1'b1, 16'h1112, 1'b0);
        wait_grants(2, "t3_g2");
        chk("t3_lock2", locked, 1);
        set_req(1, 1'b1, 16'h1113, 1'b1);
        wait_grants(3, "t3_g3");
        chk("t3_unlock", locked, 0);
        req_valid[1] = 1'b0;
        wait_grants(5, "t3_g5");
        req_valid = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), glog[i], exp_bl[i]);
        wait_idle("t3_idle");

        // Watchdog: transmitter never raises busy
        do_reset();
        tx_alive = 1'b0;
        set_req(3, 1'b1, 16'h0033, 1'b0);
        wait_grants(1, "t4_g1");
        lt = cyc;
        req_valid = '0;
        chk("t4_lock", locked, 1);
        n = 0;
        while (err !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        ecyc = cyc;
        chk("t4_err_cycle", ecyc, lt + 9);
        chk("t4_unlock", locked, 0);
        tick();
        chk("t4_err_pulse", err, 0);
        tx_alive = 1'b1;
        set_req(1, 1'b1, 16'h0101, 1'b1);
        wait_grants(2, "t4_g2");
        req_valid = '0;
        chk("t4_next", glog[1], 1);
        wait_idle("t4_idle");

        // Reset during WAIT_DONE of a locked burst
        do_reset();
        fixed_len = 20;
        set_req(1, 1'b1, 16'h1234, 1'b0);
        wait_grants(1, "t5_g1");
        req_valid = '0;
        repeat (5) tick();
        chk("t5_locked", locked, 1);
        rst_n = 1'b0;
        set_req(0, 1'b1, 16'h0A0A, 1'b1);
        set_req(1, 1'b1, 16'h1B1B, 1'b1);
        tick();
        rst_n = 1'b1;
        glog.delete();
        chk("t5_lock", locked, 0);
        chk("t5_gid", grant_id, 0);
        chk("t5_data", tx_data, 0);
        chk("t5_wr", tx_wr_en, 0);
        chk("t5_err", err, 0);
        @(negedge clk);
        chk("t5_ready", req_ready, 4'b0001);
        wait_grants(1, "t5_g");
        req_valid = '0;
        chk("t5_winner", glog[0], 0);
        wait_idle("t5_idle");

        // Valid withdrawn before ARB, then busy seen in ARB blocks granting
        do_reset();
        set_req(0, 1'b1, 16'h0F0F, 1'b1);
        wait_grants(1, "t6_g1");
        req_valid = '0;
        n = 0;
        while (!tx_busy && n < 10) begin
            tick();
            n++;
        end
        repeat (2) tick();
        set_req(2, 1'b1, 16'h2222, 1'b1);
        repeat (3) tick();
        req_valid[2] = 1'b0;
        wait_idle("t6_idle");
        chk("t6_no_grant", glog.size(), 1);
        set_req(0, 1'b1, 16'h0E0E, 1'b1);
        set_req(1, 1'b1, 16'h1E1E, 1'b1);
        wait_grants(2, "t6_g2");
        req_valid = '0;
        chk("t6_ptr", glog[1], 1);
        wait_idle("t6_idle2");
        busy_force = 1'b1;
        set_req(3, 1'b1, 16'h3E3E, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        chk("t7_blocked", req_ready, 0);
        tick();
        busy_force = 1'b0;
        wait_grants(3, "t7_g3");
        req_valid = '0;
        chk("t7_after", glog[2], 3);
        wait_idle("t7_idle");

        // Randomized traffic
        fixed_len = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(999, 0) < 3) ? 1'b0 : 1'b1;
            if ($urandom_range(99, 0) < 30) req_valid = N'($urandom);
            for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
            req_last = N'($urandom | $urandom);
            busy_force = ($urandom_range(99, 0) < 3);
            if ($urandom_range(199, 0) == 0) tx_alive = !tx_alive;
        end
        tick();
        rst_n = 1'b1;
        busy_force = 1'b0;
        tx_alive = 1'b1;
        req_valid = '0;
        wait_idle("rand_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares a single UART transmitter between NUM_REQ requesters. Each requester offers words over a valid/ready handshake. The scheduler picks one word, loads it into the transmitter with a one-cycle write pulse, and holds the data stable until the frame completes. A requester can keep the transmitter for a multi-word burst by withholding req_last. The block sits between the bus-side TX channels and the UART transmitter in the serial subsystem.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 16: word width; must match the transmitter data input.
- WDOG, 8: cycles allowed from write pulse to tx_busy rising.
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low; one clock.
- req_valid  in  NUM_REQ  word offered by requester i.
- req_data  in  NUM_REQ*DATA_W  word i is at bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  offered word ends the burst; lock is released on its transfer.
- req_ready  out  NUM_REQ  one-hot; a transfer occurs on the edge where valid[i]&ready[i].
- tx_data  out  DATA_W  to transmitter data_in; registered.
- tx_wr_en  out  1  to transmitter wr_en; one-cycle pulse.
- tx_busy  in  1  from transmitter busy.
- grant_id  out  ceil(log2 NUM_REQ)  index of the last granted requester.
- locked  out  1  a burst lock is held by grant_id.
- err  out  1  one-cycle pulse on watchdog timeout.

## Operation
- FSM states: ARB, LOAD, WAIT_BUSY, WAIT_DONE.
- **ARB**
  - Eligible set: all req_valid if unlocked; only req_valid[grant_id] if locked.
  - When tx_busy=0 and the eligible set is non-empty, pick the first eligible index searching from ptr upward with wrap.
  - req_ready for the picked index is combinational in this cycle only.
  - On the transfer edge: tx_data<=word, grant_id<=index, ptr<=index+1 mod NUM_REQ, locked<=~req_last[index], next state LOAD.
  - In every other state req_ready=0.
- **LOAD**
  - tx_wr_en=1 for exactly this cycle.
  - Watchdog counter cleared to 0.
  - Next state WAIT_BUSY.
- **WAIT_BUSY**
  - tx_busy=1 moves to WAIT_DONE.
  - Otherwise the counter increments. When it reaches WDOG: err=1 for one cycle, locked<=0, next ARB, word dropped.
- **WAIT_DONE**
  - Stay while tx_busy=1; tx_busy=0 moves to ARB.
- tx_data holds its value from the transfer edge until the next transfer; it never changes while tx_busy=1.
- ptr is an internal register, 0 after reset; requester 0 has highest priority first.
- While locked, other requesters stall even if the locked requester has req_valid=0. The lock persists until the locked requester transfers a word with req_last=1, a watchdog timeout occurs, or reset.
- A requester may drop req_valid before seeing ready; no word is consumed.
- Words offered during LOAD/WAIT_* wait for the next ARB.

## Timing
- Reset values:
  - req_ready=0, tx_wr_en=0, tx_data=0, grant_id=0, locked=0, err=0.
  - ptr=0, state=ARB.
- rst_n=0 mid-frame aborts immediately: state ARB, lock cleared, ptr 0. The transmitter shares the same reset (inverted at the top level).
- Latency:
  - Cycle 0: valid seen in ARB with tx_busy=0; ready in cycle 0.
  - Cycle 1: tx_wr_en=1.
  - Cycle 2: WAIT_BUSY.
  - The transmitter raises tx_busy 2 cycles after the pulse, i.e. cycle 3; WAIT_DONE from cycle 4.
- Back-to-back: tx_busy falls in cycle n → ARB in cycle n+1 → next ready in cycle n+1 earliest.
- tx_busy=1 seen in ARB (external use) blocks granting; no ready is issued.
- Watchdog: err in cycle LOAD+WDOG+1 if tx_busy stays 0 throughout.

## Test plan
- Single word: req_valid[2]=1, data 0x00A5, last=1, tx_busy model rises 2 cycles after pulse and is held 20 cycles → ready[2] in cycle 0, tx_wr_en in cycle 1 only, tx_data=0x00A5 held through busy, grant_id=2, locked=0.
- Round-robin: all four valid, last=1, continuous → grant order 0,1,2,3,0, one wr_en pulse per frame, no overlap with tx_busy=1.
- Burst lock: req 1 sends 3 words with last=0,0,1 while req 0 and req 3 are valid → order 1,1,1,3,0 (ptr=2 after the burst); locked=1 until the third transfer.
- Watchdog: tx_busy tied 0, one word from req 3 → err pulse exactly at cycle LOAD+9, state back to ARB, locked=0, next request granted normally.
- Reset mid-burst: rst_n=0 for 1 cycle during WAIT_DONE of a locked burst → all outputs at reset values next cycle; req 0 then wins over req 1.
- Valid withdrawn: req 2 raises valid during WAIT_DONE and drops it before ARB → no ready, no wr_en, ptr unchanged.
